// File: rtl/anti_rebote_pkg.sv
// anti_rebote_pkg: shared display constants and hex-to-seven-segment decode
package anti_rebote_pkg;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [7:0] AN_ALL_OFF = 8'hFF;
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    case (h)
      4'h0: return 7'b0000001;
      4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;
      4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;
      4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;
      4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;
      4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;
      4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;
      4'hF: return 7'b0111000;
      default: return SEG_BLANK;
    endcase
  endfunction
endpackage

// File: rtl/debouncer.sv
// debouncer: two-flop synchroniser, stability filter and registered rising-edge pulse
module debouncer
  import anti_rebote_pkg::*;
#(
  parameter int STABLE_CYCLES = 5
) (
  input  logic clock,
  input  logic reset,
  input  logic in,
  output logic out,
  output logic rise
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  logic s1, s2;
  logic [CW-1:0] cnt;
  logic done;
  always_comb done = (s2 != out) && (cnt == CW'(STABLE_CYCLES - 1));
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      out  <= 1'b0;
      rise <= 1'b0;
      cnt  <= '0;
    end else begin
      s1   <= in;
      s2   <= s1;
      out  <= done ? s2 : out;
      rise <= done && s2;
      cnt  <= (s2 == out || done) ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/anti_rebote.sv
// anti_rebote: debounced BTNC press counter shown as 8 hex digits on a scanned display
module anti_rebote
  import anti_rebote_pkg::*;
#(
  parameter int STABLE_CYCLES = 5,
  parameter int SCAN_CYCLES   = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       reset2,
  input  logic       BTNC,
  output logic [6:0] segments,
  output logic [7:0] anodos
);
  localparam int SW = $clog2(SCAN_CYCLES + 1);
  logic btn_db, rise, press, last;
  logic [31:0] count;
  logic [2:0] dig;
  logic [SW-1:0] sc;
  debouncer #(.STABLE_CYCLES(STABLE_CYCLES)) u_db (
    .clock(clock),
    .reset(reset),
    .in(BTNC),
    .out(btn_db),
    .rise(rise)
  );
  always_comb press = rise & btn_db;
  always_comb last = (sc == SW'(SCAN_CYCLES - 1));
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      count    <= '0;
      sc       <= '0;
      dig      <= '0;
      anodos   <= 8'b1111_1110;
      segments <= 7'b0000001;
    end else begin
      count    <= reset2 ? '0 : count + 32'(press);
      sc       <= last ? '0 : sc + 1'b1;
      dig      <= dig + 3'(last);
      anodos   <= AN_ALL_OFF ^ (8'd1 << dig);
      segments <= hex_to_seg(count[4*dig +: 4]);
    end
endmodule

// File: tb/tb_anti_rebote.sv
// tb_anti_rebote: directed self-checking bench for anti_rebote at default parameters
module tb_anti_rebote;
  logic clock = 1'b0, reset = 1'b0, reset2 = 1'b0, BTNC = 1'b0;
  logic [6:0] segments;
  logic [7:0] anodos;
  int n_cmp = 0, n_bad = 0;
  logic [6:0] glyph [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                            7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                            7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                            7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
  always #5 clock = ~clock;
  anti_rebote dut (
    .clock(clock),
    .reset(reset),
    .reset2(reset2),
    .BTNC(BTNC),
    .segments(segments),
    .anodos(anodos)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask
  task automatic scan(output logic [31:0] v, output int bad);
    int k;
    bit hit;
    v = '0;
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clock);
      k = -1;
      for (int j = 0; j < 8; j++) if (anodos == ~(8'd1 << j)) k = j;
      if (k < 0) bad++;
      else begin
        hit = 1'b0;
        for (int g = 0; g < 16; g++)
          if (segments == glyph[g]) begin
            v[4*k +: 4] = 4'(g);
            hit = 1'b1;
          end
        if (!hit) bad++;
      end
    end
  endtask
  task automatic check_disp(input string tag, input logic [31:0] exp);
    logic [31:0] v;
    int bad;
    scan(v, bad);
    check({tag, " shown"}, v, exp);
    check({tag, " glyphs"}, 32'(bad), 32'd0);
  endtask
  task automatic press_btn();
    @(negedge clock) BTNC = 1'b1;
    repeat (10) @(negedge clock);
    BTNC = 1'b0;
    repeat (10) @(negedge clock);
  endtask
  initial begin
    #3 reset = 1'b1;
    #1;
    check("reset anodos", anodos, 8'hFE);
    check("reset segments", segments, 7'b0000001);
    check("reset count", dut.count, 0);
    @(negedge clock) reset = 1'b0;
    BTNC = 1'b1;
    repeat (5) @(negedge clock);
    BTNC = 1'b0;
    #1 reset = 1'b1;
    #1 reset = 1'b0;
    repeat (20) @(negedge clock);
    check("abort count", dut.count, 0);
    for (int i = 0; i < 30; i++) @(negedge clock) BTNC = ~BTNC;
    BTNC = 1'b0;
    repeat (10) @(negedge clock);
    check("bounce count", dut.count, 0);
    check_disp("bounce", 32'h0);
    @(negedge clock) BTNC = 1'b1;
    repeat (7) @(posedge clock);
    @(negedge clock) check("latency 7", dut.count, 0);
    @(posedge clock);
    @(negedge clock) check("latency 8", dut.count, 1);
    repeat (2) @(negedge clock);
    BTNC = 1'b0;
    repeat (10) @(negedge clock);
    for (int i = 0; i < 40 && anodos !== 8'hFE; i++) @(negedge clock);
    check("digit0 anodos", anodos, 8'hFE);
    check("digit0 segments", segments, 7'b1001111);
    check_disp("one press", 32'h1);
    @(negedge clock) reset2 = 1'b1;
    press_btn();
    check("reset2 held", dut.count, 0);
    @(negedge clock) reset2 = 1'b0;
    press_btn();
    check("after reset2", dut.count, 1);
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("async anodos", anodos, 8'hFE);
    check("async segments", segments, 7'b0000001);
    check("async count", dut.count, 0);
    @(negedge clock) reset = 1'b0;
    repeat (6) press_btn();
    @(negedge clock) BTNC = 1'b1;
    repeat (15) @(negedge clock);
    check_disp("seven", 32'h7);
    repeat (50) @(negedge clock);
    check("held once", dut.count, 7);
    BTNC = 1'b0;
    repeat (10) @(negedge clock);
    @(negedge clock) force dut.count = 32'hFFFF_FFFF;
    @(negedge clock) release dut.count;
    check_disp("all F", 32'hFFFF_FFFF);
    press_btn();
    repeat (5) @(negedge clock);
    check("wrap count", dut.count, 0);
    check_disp("wrap", 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
